sync_fifo_ctrl: RTL and testbench

Single-clock FIFO sequencer for the dual-port RAM (dualport_ram_async) used in the FIFO subsystem, with both RAM clocks tied to the same clock.
- Owns the write and read pointers.
- Drives the RAM write/read enables and addresses.
- Produces full/empty/almost/count status and a read-data-valid strobe.
- Contains no storage itself; data flows requester -> RAM -> consumer directly.

---
 rtl/sync_fifo_ctrl_if.sv | 35 +++
 rtl/sync_fifo_ctrl.sv | 86 ++++++++
 tb/tb_sync_fifo_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if: request/status/RAM-control bundle for sync_fifo_ctrl.
// master = requester/consumer side, slave = the FIFO controller.
interface sync_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  push;
    logic                  pop;
    logic                  err_clr;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic                  ram_rd_en;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, pop, err_clr,
        input  ram_wr_en, ram_wr_addr, ram_rd_en, ram_rd_addr,
        input  rd_valid, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  push, pop, err_clr,
        output ram_wr_en, ram_wr_addr, ram_rd_en, ram_rd_addr,
        output rd_valid, full, empty, almost_full, almost_empty,
        output count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO sequencer driving an external dual-port RAM.
// Ports: clk, rst_n (async, active-low), bus (slave: push/pop/err_clr in; RAM
// enables/addresses, rd_valid, full/empty/almost_*/count, overflow/underflow out).
// Optional macro FIFO_ERR_FLAG_EN enables sticky overflow/underflow flags.
module sync_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input logic             clk,
    input logic             rst_n,
    sync_fifo_ctrl_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] occ;
    logic          full_w;
    logic          empty_w;
    logic          push_acc;
    logic          pop_acc;
    logic          rd_valid_q;

    // Extra pointer MSB distinguishes full from empty at equal addresses.
    assign occ     = wr_ptr - rd_ptr;
    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    assign push_acc = bus.push & ~full_w;
    assign pop_acc  = bus.pop & ~empty_w;

    // Enables gated by rst_n so nothing reaches the RAM during reset.
    assign bus.ram_wr_en   = push_acc & rst_n;
    assign bus.ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign bus.ram_rd_en   = pop_acc & rst_n;
    assign bus.ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    assign bus.count        = occ;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (occ >= PW'(AF_LEVEL));
    assign bus.almost_empty = (occ <= PW'(AE_LEVEL));
    assign bus.rd_valid     = rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            // RAM read port is registered: data appears one cycle later.
            rd_valid_q <= pop_acc;
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    logic ovf_q;
    logic unf_q;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.push && full_w)  ovf_q <= 1'b1;
            else if (bus.err_clr)    ovf_q <= 1'b0;
            if (bus.pop && empty_w)  unf_q <= 1'b1;
            else if (bus.err_clr)    unf_q <= 1'b0;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: table-driven directed bench for sync_fifo_ctrl.
// Vectors cover fill, overflow, drain, underflow, wrap and simultaneous ops.
module tb_sync_fifo_ctrl;
`ifdef FIFO_ERR_FLAG_EN
    localparam int ERR = 1;
`else
    localparam int ERR = 0;
`endif

    typedef struct {
        int push;
        int pop;
        int we;
        int re;
        int wa;
        int ra;
        int cnt;
        int rdv;
        int ovf;
        int unf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    vec_t vq[$];

    sync_fifo_ctrl_if #(.ADDR_WIDTH(4)) bus ();

    sync_fifo_ctrl #(
        .ADDR_WIDTH(4),
        .AF_LEVEL  (14),
        .AE_LEVEL  (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s [%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    function automatic void add(input int p, input int q, input int we, input int re,
                                input int wa, input int ra, input int c, input int rdv,
                                input int ovf, input int unf);
        vec_t v;
        v.push = p; v.pop = q; v.we = we; v.re = re; v.wa = wa; v.ra = ra;
        v.cnt = c; v.rdv = rdv; v.ovf = ovf; v.unf = unf;
        vq.push_back(v);
    endfunction

    task automatic flags_chk(input int idx, input int c);
        chk("count", idx, int'(bus.count), c);
        chk("full", idx, int'(bus.full), (c == 16) ? 1 : 0);
        chk("empty", idx, int'(bus.empty), (c == 0) ? 1 : 0);
        chk("almost_full", idx, int'(bus.almost_full), (c >= 14) ? 1 : 0);
        chk("almost_empty", idx, int'(bus.almost_empty), (c <= 2) ? 1 : 0);
    endtask

    task automatic step(input vec_t v, input int idx);
        bus.push = v.push[0];
        bus.pop  = v.pop[0];
        #1;
        chk("ram_wr_en", idx, int'(bus.ram_wr_en), v.we);
        chk("ram_rd_en", idx, int'(bus.ram_rd_en), v.re);
        if (v.we != 0) chk("ram_wr_addr", idx, int'(bus.ram_wr_addr), v.wa);
        if (v.re != 0) chk("ram_rd_addr", idx, int'(bus.ram_rd_addr), v.ra);
        @(posedge clk);
        #1;
        flags_chk(idx, v.cnt);
        chk("rd_valid", idx, int'(bus.rd_valid), v.rdv);
        chk("overflow", idx, int'(bus.overflow), v.ovf);
        chk("underflow", idx, int'(bus.underflow), v.unf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;

        // 1: fill 16
        for (int i = 0; i < 16; i++) add(1, 0, 1, 0, i, 0, i + 1, 0, 0, 0);
        // 2: push while full
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 16, 0, ERR, 0);
        // 3: drain 16, then pop while empty
        for (int i = 0; i < 16; i++) add(0, 1, 0, 1, 0, i, 15 - i, 1, ERR, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, ERR, ERR);
        // 4: push 10, pop 10, push 10 across the wrap
        for (int i = 0; i < 10; i++) add(1, 0, 1, 0, i, 0, i + 1, 0, ERR, ERR);
        for (int i = 0; i < 10; i++) add(0, 1, 0, 1, 0, i, 9 - i, 1, ERR, ERR);
        for (int i = 0; i < 10; i++) add(1, 0, 1, 0, (10 + i) % 16, 0, i + 1, 0, ERR, ERR);
        // 5a: down to 5, then simultaneous x4
        for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 0, 10 + i, 9 - i, 1, ERR, ERR);
        for (int i = 0; i < 4; i++) add(1, 1, 1, 1, 4 + i, (15 + i) % 16, 5, 1, ERR, ERR);
        // 5b: drain, simultaneous from empty
        for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 0, 3 + i, 4 - i, 1, ERR, ERR);
        add(1, 1, 1, 0, 8, 0, 1, 0, ERR, ERR);
        for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 9 + i, 8 + i, 1, 1, ERR, ERR);
        // 5c: fill, simultaneous at full
        for (int i = 0; i < 15; i++) add(1, 0, 1, 0, (12 + i) % 16, 0, 2 + i, 0, ERR, ERR);
        add(1, 1, 0, 1, 0, 11, 15, 1, ERR, ERR);

        bus.push    = 1'b1;
        bus.pop     = 1'b1;
        bus.err_clr = 1'b0;
        rst_n       = 1'b0;
        #12;
        chk("rst_wr_en", 0, int'(bus.ram_wr_en), 0);
        chk("rst_rd_en", 0, int'(bus.ram_rd_en), 0);
        flags_chk(0, 0);
        chk("rst_rd_valid", 0, int'(bus.rd_valid), 0);
        chk("rst_overflow", 0, int'(bus.overflow), 0);
        chk("rst_underflow", 0, int'(bus.underflow), 0);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) step(vq[i], i + 1);

        // err_clr: refill to full, set-wins, then clear
        bus.push = 1'b1;
        bus.pop  = 1'b0;
        @(posedge clk);
        #1;
        chk("refill_count", 900, int'(bus.count), 16);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("setwins_overflow", 901, int'(bus.overflow), ERR);
        chk("clr_underflow", 901, int'(bus.underflow), 0);
        bus.push = 1'b0;
        @(posedge clk);
        #1;
        chk("clr_overflow", 902, int'(bus.overflow), 0);
        chk("clr_count", 902, int'(bus.count), 16);
        bus.err_clr = 1'b0;

        // 6: reset mid-operation with a pop in flight
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.push = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
        end
        bus.push = 1'b0;
        chk("pre_rst_count", 910, int'(bus.count), 7);
        bus.pop = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_rd_valid", 911, int'(bus.rd_valid), 1);
        bus.push = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        flags_chk(912, 0);
        chk("midrst_rd_valid", 912, int'(bus.rd_valid), 0);
        chk("midrst_wr_en", 912, int'(bus.ram_wr_en), 0);
        chk("midrst_rd_en", 912, int'(bus.ram_rd_en), 0);
        bus.pop = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_wr_en", 913, int'(bus.ram_wr_en), 1);
        chk("post_rst_wr_addr", 913, int'(bus.ram_wr_addr), 0);
        @(posedge clk);
        #1;
        chk("post_rst_count", 914, int'(bus.count), 1);
        bus.push = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
